// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encoding and status-flag bit positions for alu_pipe
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_PASSA = 4'd10,
        OP_PASSB = 4'd11,
        OP_ACC   = 4'd12
    } op_e;

    // Flag vector layout: {err, v, c, n, z}
    localparam int F_Z    = 0;
    localparam int F_N    = 1;
    localparam int F_C    = 2;
    localparam int F_V    = 3;
    localparam int F_ERR  = 4;
    localparam int NFLAGS = 5;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// alu_core : combinational ALU datapath (op, a, b, acc) -> (res, flags)
// ALU_PIPE_SAT_EN : saturate ADD/SUB/ACC to signed max/min on overflow
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc,
    output logic [W-1:0] res,
    output logic [4:0]   flags
);

    localparam int SHW = $clog2(W);
    localparam logic [SHW:0] W_SH = (SHW+1)'(W);

    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W:0]     sum;
    logic [W-1:0]   arith;
    logic [W-1:0]   sll_r;
    logic [W-1:0]   srl_r;
    logic [W-1:0]   sra_r;
    logic [SHW-1:0] shamt;
    logic           is_acc;
    logic           is_sub;
    logic           is_arith;
    logic           ovf;
    logic           sh_over;
    logic           err;

    // ACC shares the adder: x = accumulator, y = operand A
    assign is_acc   = (op == OP_ACC);
    assign is_sub   = (op == OP_SUB);
    assign is_arith = is_acc || is_sub || (op == OP_ADD);
    assign x        = is_acc ? acc : a;
    assign y        = is_acc ? a : b;

    // Bit W is carry for add and borrow (x<y unsigned) for subtract
    assign sum = is_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    assign ovf = is_sub ? ((x[W-1] != y[W-1]) && (sum[W-1] != x[W-1]))
                        : ((x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]));

`ifdef ALU_PIPE_SAT_EN
    logic [W-1:0] sat_val;
    assign sat_val = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign arith   = ovf ? sat_val : sum[W-1:0];
`else
    assign arith   = sum[W-1:0];
`endif

    assign shamt   = b[SHW-1:0];
    assign sh_over = ({1'b0, shamt} >= W_SH);
    assign sll_r   = sh_over ? '0 : (a << shamt);
    assign srl_r   = sh_over ? '0 : (a >> shamt);
    assign sra_r   = sh_over ? {W{a[W-1]}} : $unsigned($signed(a) >>> shamt);

    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ACC: res = arith;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SLL:   res = sll_r;
            OP_SRL:   res = srl_r;
            OP_SRA:   res = sra_r;
            OP_SLT:   res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res = {{(W-1){1'b0}}, (a < b)};
            OP_PASSA: res = a;
            OP_PASSB: res = b;
            default:  err = 1'b1;
        endcase

        flags = '0;
        if (err) begin
            flags[F_ERR] = 1'b1;
        end else begin
            flags[F_Z] = (res == '0);
            flags[F_N] = res[W-1];
            if (is_arith) begin
                flags[F_C] = sum[W];
                flags[F_V] = ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe : two-stage pipelined ALU with valid/ready handshake and accumulator
// ALU_PIPE_SAT_EN : saturating arithmetic (handled inside alu_core)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [4:0]   out_flags
);

    logic         s1_valid;
    logic [3:0]   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic         s2_valid;
    logic [W-1:0] s2_res;
    logic [4:0]   s2_flags;
    logic [W-1:0] acc;
    logic [W-1:0] core_acc;
    logic [W-1:0] core_res;
    logic [4:0]   core_flags;
    logic         s1_adv;
    logic         s2_adv;
    logic         acc_upd;

    // Ready ripples back combinationally so a full pipe drains and refills each clk
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // A clear on the same edge as an ACC beat makes that beat start from zero
    assign core_acc = acc_clr ? '0 : acc;
    assign acc_upd  = s1_valid && s2_adv && (s1_op == OP_ACC);

    alu_core #(
        .W (W)
    ) u_core (
        .op    (s1_op),
        .a     (s1_a),
        .b     (s1_b),
        .acc   (core_acc),
        .res   (core_res),
        .flags (core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= core_res;
                s2_flags <= core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_upd) begin
            acc <= core_res;
        end
    end

    assign out_valid = s2_valid;
    assign out_res   = s2_res;
    assign out_flags = s2_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe : scoreboard testbench for alu_pipe (W=8)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         acc_clr   = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   in_op     = 4'd0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_res;
    logic [4:0]   out_flags;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;

    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    logic [7:0]  m_acc = 8'h00;

    always #5 clk = ~clk;

    alu_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    // Reference model on integers; returns {flags, res}
    function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, us, ss;
        logic [7:0] r;
        logic c, v;
        logic signed [7:0] t;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; r = 8'h00; t = $signed(a);
        if (op == 4'd12) begin
            ua = int'(m_acc); ub = int'(a);
            sa = int'($signed(m_acc)); sb = int'($signed(a));
        end
        case (op)
            4'd0, 4'd12: begin
                us = ua + ub; ss = sa + sb;
                r = us[7:0]; c = (us > 255); v = (ss > 127) || (ss < -128);
            end
            4'd1: begin
                us = ua - ub; ss = sa - sb;
                r = us[7:0]; c = (ua < ub); v = (ss > 127) || (ss < -128);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[2:0];
            4'd6:  r = a >> b[2:0];
            4'd7:  r = t >>> b[2:0];
            4'd8:  r = (sa < sb) ? 8'd1 : 8'd0;
            4'd9:  r = (ua < ub) ? 8'd1 : 8'd0;
            4'd10: r = a;
            4'd11: r = b;
            default: return {5'b10000, 8'h00};
        endcase
`ifdef ALU_PIPE_SAT_EN
        if (v) r = (ss > 127) ? 8'h7F : 8'h80;
`endif
        if (op == 4'd12) m_acc = r;
        return {1'b0, v, c, r[7], (r == 8'h00), r};
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin : monitor
        logic [12:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            got_q.push_back({out_flags, out_res});
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got flags=%b res=%h, required no output", out_flags, out_res);
            end else begin
                e = exp_q.pop_front();
                if ({out_flags, out_res} !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got flags=%b res=%h, required flags=%b res=%h",
                             out_flags, out_res, e[12:8], e[7:0]);
                end
            end
        end
        if (rst_n && in_valid && in_ready)
            exp_q.push_back(model(in_op, in_a, in_b));
    end

    task automatic drive_beat(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL drive_timeout: in_ready never high, required accept within 200 clk");
        end
    endtask

    task automatic wait_got(input int n);
        int i;
        i = 0;
        while (got_q.size() < n && i < 300) begin
            @(posedge clk); #1;
            i++;
        end
        if (got_q.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL got_timeout: got %0d results, required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        int base;
        #2 rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_flags, out_res} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b flags=%b res=%h, required all 0", out_valid, out_flags, out_res);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        drive_beat(OP_ADD, 8'h01, 8'h02);
        drive_beat(OP_ADD, 8'h03, 8'h04);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_flags !== 5'd0 || out_res !== 8'd0) begin
            n_err++;
            $display("FAIL reset_midstream: got valid=%b flags=%b res=%h, required 0/0/00", out_valid, out_flags, out_res);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete(); got_q.delete(); m_acc = 8'h00;
        base = n_out;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (n_out != base) begin
            n_err++;
            $display("FAIL reset_stale: got %0d outputs after reset, required 0", n_out - base);
        end
    endtask

    task automatic test_add_latency();
        logic [12:0] exp;
`ifdef ALU_PIPE_SAT_EN
        exp = {5'b01000, 8'h7F};
`else
        exp = {5'b01010, 8'h80};
`endif
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h7F; in_b = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_latency_early: got out_valid=%b after 1 clk, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL add_latency: got out_valid=%b after 2 clk, required 1", out_valid);
        end
        n_cmp++;
        if ({out_flags, out_res} !== exp) begin
            n_err++;
            $display("FAIL add_result: got flags=%b res=%h, required flags=%b res=%h", out_flags, out_res, exp[12:8], exp[7:0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_ops();
        logic [3:0]  ops [11] = '{4'd1, 4'd9, 4'd8, 4'hF, 4'd7, 4'd5, 4'd6, 4'd4, 4'd11, 4'd0, 4'd1};
        logic [7:0]  as  [11] = '{8'h00, 8'h01, 8'h01, 8'h12, 8'h80, 8'h81, 8'h81, 8'hAA, 8'h00, 8'hFF, 8'h80};
        logic [7:0]  bs  [11] = '{8'h01, 8'hFF, 8'hFF, 8'h34, 8'h03, 8'h01, 8'h07, 8'hAA, 8'h9C, 8'h01, 8'h01};
        logic [12:0] ex  [11] = '{{5'b00110, 8'hFF}, {5'b00000, 8'h01}, {5'b00001, 8'h00},
                                  {5'b10000, 8'h00}, {5'b00010, 8'hF0}, {5'b00000, 8'h02},
                                  {5'b00000, 8'h01}, {5'b00001, 8'h00}, {5'b00010, 8'h9C},
                                  {5'b00101, 8'h00},
`ifdef ALU_PIPE_SAT_EN
                                  {5'b01010, 8'h80}};
`else
                                  {5'b01000, 8'h7F}};
`endif
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) drive_beat(ops[i], as[i], bs[i]);
        in_valid = 1'b0;
        wait_got(11);
        for (int i = 0; i < 11 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== ex[i]) begin
                n_err++;
                $display("FAIL ops_%0d op=%h: got flags=%b res=%h, required flags=%b res=%h",
                         i, ops[i], got_q[i][12:8], got_q[i][7:0], ex[i][12:8], ex[i][7:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold;
        int base;
        got_q.delete();
        base = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) drive_beat(OP_ADD, 8'(i), 8'(i));
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_ready_one: got in_ready=%b with 1 stored, required 1", in_ready);
                end
                @(posedge clk); #1;
                hold = out_res;
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_ready_full: got in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
                end
                @(posedge clk); #1;
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_res !== hold) begin
                    n_err++;
                    $display("FAIL bp_hold: got in_ready=%b out_valid=%b res=%h, required 0/1/%h", in_ready, out_valid, out_res, hold);
                end
                out_ready = 1'b1;
            end
        join
        wait_got(4);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (n_out - base != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs (%0d pending), required 4 (0)", n_out - base, exp_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i][7:0] !== 8'(2 * (i + 1))) begin
                n_err++;
                $display("FAIL bp_order_%0d: got res=%h, required %h", i, got_q[i][7:0], 8'(2 * (i + 1)));
            end
        end
    endtask

    task automatic test_acc();
        logic [7:0] ex [4] = '{8'h10, 8'h20, 8'h30, 8'h05};
        out_ready = 1'b1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_acc = 8'h00;
        got_q.delete();
        for (int i = 0; i < 3; i++) drive_beat(OP_ACC, 8'h10, 8'h00);
        m_acc = 8'h00;
        drive_beat(OP_ACC, 8'h05, 8'h00);
        in_valid = 1'b0;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        wait_got(4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== {5'b00000, ex[i]}) begin
                n_err++;
                $display("FAIL acc_%0d: got flags=%b res=%h, required flags=00000 res=%h", i, got_q[i][12:8], got_q[i][7:0], ex[i]);
            end
        end
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_acc = 8'h00;
    endtask

    task automatic test_random();
        bit done;
        int base;
        int i;
        done = 1'b0;
        base = n_out;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    drive_beat(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        i = 0;
        while (exp_q.size() != 0 && i < 50) begin
            @(posedge clk); #1;
            i++;
        end
        n_cmp++;
        if (n_out - base != 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_count: got %0d outputs (%0d pending), required 1000 (0)", n_out - base, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_ops();
        test_backpressure();
        test_acc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
